// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues instruction reads, and registers each fetched word into the IF/ID latch.
// Latency: a word returned with ihit in cycle N appears on ifid_* after edge N; a redirect in cycle N gives imemaddr=target in cycle N+1.
// Backpressure: stall holds the PC, IF/ID and FSM (redirect overrides it); ihit low or HALT inserts bubbles.
module fetch_stage #(
  parameter logic [31:0] PC_INIT  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic        halted
);

  // Opcode that stops the front end until a reset or downstream redirect.
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  fetch_state_t state, state_nxt;

  logic [31:0] pc_nxt;
  logic [31:0] ifid_instr_nxt;
  logic [31:0] ifid_npc_nxt;
  logic        ifid_valid_nxt;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_aligned;
  logic        load_is_halt;

  // Sequential PC increment wraps naturally at 2^32.
  assign pc_plus4         = pc + 32'd4;
  // Instructions are word aligned; any low bits from the redirect source are dropped.
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign load_is_halt     = (imemload[31:26] == HALT_OPCODE);

  // Memory-side and status outputs depend on registered state only, so
  // nothing from imemload/ihit reaches an output in the same cycle.
  assign imemaddr = pc;
  assign imemREN  = (state == FETCH);
  assign halted   = (state == HALT);

  // Next-state and next-latch selection: redirect beats stall beats ihit.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    ifid_instr_nxt = ifid_instr;
    ifid_npc_nxt   = ifid_npc;
    ifid_valid_nxt = ifid_valid;

    if (redirect_valid) begin
      // Taken branch/jump downstream: squash the latch, cancel any wrong-path HALT.
      pc_nxt         = redirect_aligned;
      ifid_instr_nxt = NOP_WORD;
      ifid_npc_nxt   = 32'd0;
      ifid_valid_nxt = 1'b0;
      state_nxt      = FETCH;
    end else if (stall) begin
      // Hazard unit holds everything; defaults already keep all state.
      state_nxt = state;
    end else begin
      unique case (state)
        FETCH: begin
          if (ihit) begin
            ifid_instr_nxt = imemload;
            ifid_npc_nxt   = pc_plus4;
            ifid_valid_nxt = 1'b1;
            if (load_is_halt) begin
              // The HALT word itself flows down the pipe; the PC parks on it.
              state_nxt = HALT;
            end else begin
              pc_nxt = pc_plus4;
            end
          end else begin
            // Memory not ready: hold the PC and feed a bubble to decode.
            ifid_instr_nxt = NOP_WORD;
            ifid_npc_nxt   = 32'd0;
            ifid_valid_nxt = 1'b0;
          end
        end
        HALT: begin
          ifid_instr_nxt = NOP_WORD;
          ifid_npc_nxt   = 32'd0;
          ifid_valid_nxt = 1'b0;
        end
        default: begin
          state_nxt = FETCH;
        end
      endcase
    end
  end

  // State, PC and IF/ID registers with synchronous reset taking priority over all inputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= FETCH;
      pc         <= PC_INIT;
      ifid_instr <= NOP_WORD;
      ifid_npc   <= 32'd0;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ifid_instr <= ifid_instr_nxt;
      ifid_npc   <= ifid_npc_nxt;
      ifid_valid <= ifid_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded directed bench for fetch_stage.
// Latency: each step drives one cycle and compares the registered result #1 after the edge.
// Backpressure: stall/redirect/HALT sequences are driven explicitly from the step list.
module tb_fetch_stage;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;
  logic        halted;

  fetch_stage #(
    .PC_INIT (32'h0000_0000),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ihit          (ihit),
    .imemload      (imemload),
    .imemREN       (imemREN),
    .imemaddr      (imemaddr),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_npc      (ifid_npc),
    .ifid_valid    (ifid_valid),
    .halted        (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // State the bench believes is currently registered in the DUT (for in-cycle checks).
  logic        have_prev = 1'b0;
  logic [31:0] prev_pc;
  logic        prev_halted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, push the expected post-edge state, then pop and compare.
  task automatic step(input string tag,
                      input logic rst, input logic hit, input logic [31:0] load,
                      input logic stl, input logic rv, input logic [31:0] rpc,
                      input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_npc, input logic e_valid, input logic e_halted);
    exp_t e;
    exp_t got;
    @(negedge CLK);
    RST            = rst;
    ihit           = hit;
    imemload       = load;
    stall          = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    // Outputs seen mid-cycle must reflect only registered state, not this cycle's inputs.
    if (have_prev) begin
      chk({tag, ":pre_addr"}, imemaddr, prev_pc);
      chk({tag, ":pre_ren"}, {31'd0, imemREN}, {31'd0, ~prev_halted});
    end
    e.pc     = e_pc;
    e.instr  = e_instr;
    e.npc    = e_npc;
    e.valid  = e_valid;
    e.halted = e_halted;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, ":sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      chk({tag, ":pc"},       pc,         got.pc);
      chk({tag, ":imemaddr"}, imemaddr,   got.pc);
      chk({tag, ":instr"},    ifid_instr, got.instr);
      chk({tag, ":npc"},      ifid_npc,   got.npc);
      chk({tag, ":valid"},    {31'd0, ifid_valid}, {31'd0, got.valid});
      chk({tag, ":halted"},   {31'd0, halted},     {31'd0, got.halted});
      chk({tag, ":ren"},      {31'd0, imemREN},    {31'd0, ~got.halted});
      prev_pc     = got.pc;
      prev_halted = got.halted;
      have_prev   = 1'b1;
    end
  endtask

  localparam logic [31:0] ADDI = 32'h2001_0005;
  localparam logic [31:0] ADD  = 32'h0022_1820;
  localparam logic [31:0] LW   = 32'h8C22_0004;
  localparam logic [31:0] SW   = 32'hAC01_0000;
  localparam logic [31:0] BEQ  = 32'h1111_1111;
  localparam logic [31:0] HLT  = 32'hFFFF_FFFF;
  localparam logic [31:0] HLT2 = 32'hFC00_0000;

  initial begin
    RST = 1'b1; ihit = 1'b0; imemload = 32'd0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;

    //          tag       rst  hit  load   stl  rv   rpc            pc            instr  npc           v    h
    step("rst0",  1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0,        32'h0,        32'h0, 32'h0,        1'b0, 1'b0);
    step("rst1",  1'b1, 1'b1, ADDI,  1'b1, 1'b1, 32'h40,       32'h0,        32'h0, 32'h0,        1'b0, 1'b0);
    // Sequential fetch from reset.
    step("f0",    1'b0, 1'b1, ADDI,  1'b0, 1'b0, 32'd0,        32'h4,        ADDI,  32'h4,        1'b1, 1'b0);
    step("f1",    1'b0, 1'b1, ADD,   1'b0, 1'b0, 32'd0,        32'h8,        ADD,   32'h8,        1'b1, 1'b0);
    step("f2",    1'b0, 1'b1, LW,    1'b0, 1'b0, 32'd0,        32'hC,        LW,    32'hC,        1'b1, 1'b0);
    step("f3",    1'b0, 1'b1, ADD,   1'b0, 1'b0, 32'd0,        32'h10,       ADD,   32'h10,       1'b1, 1'b0);
    // Memory miss for three cycles: bubbles, PC holds.
    step("miss0", 1'b0, 1'b0, HLT,   1'b0, 1'b0, 32'd0,        32'h10,       32'h0, 32'h0,        1'b0, 1'b0);
    step("miss1", 1'b0, 1'b0, HLT,   1'b0, 1'b0, 32'd0,        32'h10,       32'h0, 32'h0,        1'b0, 1'b0);
    step("miss2", 1'b0, 1'b0, ADDI,  1'b0, 1'b0, 32'd0,        32'h10,       32'h0, 32'h0,        1'b0, 1'b0);
    step("hit10", 1'b0, 1'b1, SW,    1'b0, 1'b0, 32'd0,        32'h14,       SW,    32'h14,       1'b1, 1'b0);
    // Stall with ihit: everything frozen, including a would-be HALT word.
    step("stl0",  1'b0, 1'b1, BEQ,   1'b1, 1'b0, 32'd0,        32'h14,       SW,    32'h14,       1'b1, 1'b0);
    step("stl1",  1'b0, 1'b1, HLT,   1'b1, 1'b0, 32'd0,        32'h14,       SW,    32'h14,       1'b1, 1'b0);
    // Redirect overrides stall.
    step("stlrd", 1'b0, 1'b1, ADDI,  1'b1, 1'b1, 32'h40,       32'h40,       32'h0, 32'h0,        1'b0, 1'b0);
    step("f40",   1'b0, 1'b1, BEQ,   1'b0, 1'b0, 32'd0,        32'h44,       BEQ,   32'h44,       1'b1, 1'b0);
    // Unaligned redirect target has its low bits cleared.
    step("rd103", 1'b0, 1'b1, ADD,   1'b0, 1'b1, 32'h103,      32'h100,      32'h0, 32'h0,        1'b0, 1'b0);
    step("f100",  1'b0, 1'b1, LW,    1'b0, 1'b0, 32'd0,        32'h104,      LW,    32'h104,      1'b1, 1'b0);
    // HALT fetched in the same cycle as a redirect is cancelled.
    step("rdhlt", 1'b0, 1'b1, HLT,   1'b0, 1'b1, 32'h20,       32'h20,       32'h0, 32'h0,        1'b0, 1'b0);
    // Real HALT at 0x20.
    step("hlt",   1'b0, 1'b1, HLT,   1'b0, 1'b0, 32'd0,        32'h20,       HLT,   32'h24,       1'b1, 1'b1);
    step("hw0",   1'b0, 1'b1, ADDI,  1'b0, 1'b0, 32'd0,        32'h20,       32'h0, 32'h0,        1'b0, 1'b1);
    step("hw1",   1'b0, 1'b0, ADDI,  1'b0, 1'b0, 32'd0,        32'h20,       32'h0, 32'h0,        1'b0, 1'b1);
    step("hstl",  1'b0, 1'b1, ADDI,  1'b1, 1'b0, 32'd0,        32'h20,       32'h0, 32'h0,        1'b0, 1'b1);
    // Redirect leaves HALT.
    step("hrd8",  1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h8,        32'h8,        32'h0, 32'h0,        1'b0, 1'b0);
    step("f8",    1'b0, 1'b1, ADD,   1'b0, 1'b0, 32'd0,        32'hC,        ADD,   32'hC,        1'b1, 1'b0);
    // PC wrap at the top of the address space.
    step("rdtop", 1'b0, 1'b1, ADD,   1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 32'h0,       1'b0, 1'b0);
    step("wrap",  1'b0, 1'b1, ADDI,  1'b0, 1'b0, 32'd0,        32'h0,        ADDI,  32'h0,        1'b1, 1'b0);
    step("f0b",   1'b0, 1'b1, LW,    1'b0, 1'b0, 32'd0,        32'h4,        LW,    32'h4,        1'b1, 1'b0);
    // HALT opcode with zero low bits, then reset mid-HALT beats redirect.
    step("rd30",  1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h30,       32'h30,       32'h0, 32'h0,        1'b0, 1'b0);
    step("hlt2",  1'b0, 1'b1, HLT2,  1'b0, 1'b0, 32'd0,        32'h30,       HLT2,  32'h34,       1'b1, 1'b1);
    step("hw2",   1'b0, 1'b1, ADD,   1'b0, 1'b0, 32'd0,        32'h30,       32'h0, 32'h0,        1'b0, 1'b1);
    step("rsth",  1'b1, 1'b1, ADD,   1'b0, 1'b1, 32'h50,       32'h0,        32'h0, 32'h0,        1'b0, 1'b0);
    step("post",  1'b0, 1'b1, ADDI,  1'b0, 1'b0, 32'd0,        32'h4,        ADDI,  32'h4,        1'b1, 1'b0);

    chk("sb_drain", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
